display_timings: RTL

//  Raster timing generator in the clk_pix domain, directly downstream of the pixel clock generator.

---
 rtl/display_pkg.sv | 18 +
 rtl/sync_2ff.sv | 21 ++
 rtl/display_timings.sv | 98 +++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Default video mode (640x480 @ 60 Hz, 25.2 MHz pixel clock) and the coordinate type.
package display_pkg;

    localparam int   DT_CORDW    = 10;
    localparam int   DT_H_ACTIVE = 640;
    localparam int   DT_H_FP     = 16;
    localparam int   DT_H_SYNC   = 96;
    localparam int   DT_H_BP     = 48;
    localparam int   DT_V_ACTIVE = 480;
    localparam int   DT_V_FP     = 10;
    localparam int   DT_V_SYNC   = 2;
    localparam int   DT_V_BP     = 33;
    localparam logic DT_H_POL    = 1'b0;
    localparam logic DT_V_POL    = 1'b0;

    typedef logic [DT_CORDW-1:0] coord_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single-bit level crossing into clk.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/display_timings.sv
// Raster timing generator: coordinates, syncs, data enable and frame/line strobes.
// Build option DT_LOCK_SYNC_EN: hold in reset until the synchronised clk_locked is high.
module display_timings
    import display_pkg::*;
#(
    parameter int   CORDW    = DT_CORDW,
    parameter int   H_ACTIVE = DT_H_ACTIVE,
    parameter int   H_FP     = DT_H_FP,
    parameter int   H_SYNC   = DT_H_SYNC,
    parameter int   H_BP     = DT_H_BP,
    parameter int   V_ACTIVE = DT_V_ACTIVE,
    parameter int   V_FP     = DT_V_FP,
    parameter int   V_SYNC   = DT_V_SYNC,
    parameter int   V_BP     = DT_V_BP,
    parameter logic H_POL    = DT_H_POL,
    parameter logic V_POL    = DT_V_POL
) (
    input  logic             clk_pix,
    input  logic             rst_n,
    input  logic             clk_locked,
    output logic [CORDW-1:0] sx,
    output logic [CORDW-1:0] sy,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             frame,
    output logic             line
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CORDW-1:0] H_LAST = CORDW'(H_TOTAL - 1);
    localparam logic [CORDW-1:0] V_LAST = CORDW'(V_TOTAL - 1);
    localparam logic [CORDW-1:0] H_ACT  = CORDW'(H_ACTIVE);
    localparam logic [CORDW-1:0] V_ACT  = CORDW'(V_ACTIVE);
    localparam logic [CORDW-1:0] HS_BEG = CORDW'(H_ACTIVE + H_FP);
    localparam logic [CORDW-1:0] HS_END = CORDW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CORDW-1:0] VS_BEG = CORDW'(V_ACTIVE + V_FP);
    localparam logic [CORDW-1:0] VS_END = CORDW'(V_ACTIVE + V_FP + V_SYNC);

    if (H_FP == 0 || H_SYNC == 0 || H_BP == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
        H_TOTAL > (1 << CORDW) || V_TOTAL > (1 << CORDW)) begin : g_bad_params
        $error("display_timings: zero porch/sync width or total exceeds 2**CORDW");
    end

    logic run;

`ifdef DT_LOCK_SYNC_EN
    logic lock_s;

    sync_2ff u_lock_sync (
        .clk   (clk_pix),
        .rst_n (rst_n),
        .d     (clk_locked),
        .q     (lock_s)
    );

    assign run = rst_n && lock_s;
`else
    logic unused_clk_locked;
    assign unused_clk_locked = clk_locked;
    assign run = rst_n;
`endif

    logic [CORDW-1:0] sx_nx, sy_nx;

    always_comb begin
        sx_nx = sx + CORDW'(1);
        sy_nx = sy;
        if (sx == H_LAST) begin
            sx_nx = '0;
            sy_nx = (sy == V_LAST) ? '0 : sy + CORDW'(1);
        end
    end

    // Flags decode the next coordinates so they line up with the registered sx/sy.
    always_ff @(posedge clk_pix) begin
        if (!run) begin
            sx    <= H_LAST;
            sy    <= V_LAST;
            hsync <= !H_POL;
            vsync <= !V_POL;
            de    <= 1'b0;
            frame <= 1'b0;
            line  <= 1'b0;
        end else begin
            sx    <= sx_nx;
            sy    <= sy_nx;
            hsync <= (sx_nx >= HS_BEG && sx_nx < HS_END) ? H_POL : !H_POL;
            vsync <= (sy_nx >= VS_BEG && sy_nx < VS_END) ? V_POL : !V_POL;
            de    <= (sx_nx < H_ACT) && (sy_nx < V_ACT);
            frame <= (sx_nx == '0) && (sy_nx == '0);
            line  <= (sx_nx == '0);
        end
    end

endmodule
